// File: rtl/decode_scoreboard.sv
// decode_scoreboard
// Register-hazard scheduler for the decode stage. Each architectural
// register (except x0) has a small counter of writes that decode has issued
// and writeback has not yet retired. Decode is stalled on RAW hazards and
// when a counter is at its maximum (WAW saturation). The stall is released
// when writeback retires the pending write.
//
// Optional feature macro: SB_FORWARD_EN
//   When defined, a source operand whose only outstanding write is being
//   written back this very cycle is bypassed from wd3 (fwd_rs1/fwd_rs2 = 1)
//   instead of stalling. When undefined, fwd_rs1/fwd_rs2 are tied to 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   issue_valid           decode holds a valid instruction
//   rs1, rs2, use_rs1/2   source register addresses and read enables
//   rd, regwrite          destination register and write enable
//   flush                 kill the instruction in decode
//   wb_valid, wb_rd       writeback strobe and address (rf we3/ad3)
//   stall                 hold fetch/decode this cycle
//   issue_fire            instruction leaves decode this cycle
//   busy                  at least one write outstanding
//   outstanding           total outstanding writes
//   stall_cycles          saturating count of stalled cycles
//   err_underflow         sticky: writeback with nothing outstanding
//   fwd_rs1, fwd_rs2      operand bypass selects
`default_nettype none

module decode_scoreboard #(
  parameter int AW     = 5,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [AW-1:0]       rs1,
  input  logic [AW-1:0]       rs2,
  input  logic                use_rs1,
  input  logic                use_rs2,
  input  logic [AW-1:0]       rd,
  input  logic                regwrite,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  output logic                stall,
  output logic                issue_fire,
  output logic                busy,
  output logic [AW+CNT_W-1:0] outstanding,
  output logic [PERF_W-1:0]   stall_cycles,
  output logic                err_underflow,
  output logic                fwd_rs1,
  output logic                fwd_rs2
);

  localparam int NREG = 2**AW;
  localparam int OW   = AW + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Per-register counter; its value encodes the register state:
  // 0 = IDLE, 1..max-1 = PENDING, max = FULL.
  logic [CNT_W-1:0] cnt      [NREG];
  logic [CNT_W-1:0] cnt_next [NREG];

  logic raw1, raw2, sat;
  logic haz1, haz2;
  logic fwd1, fwd2;
  logic inc_any, dec_any, underflow_hit;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    sat_inc = (v == '1) ? v : v + PERF_W'(1);
  endfunction

  function automatic logic is_full(input logic [CNT_W-1:0] c);
    is_full = (c == CNT_MAX);
  endfunction

  // Hazard evaluation and decode handshake (combinational)
  always_comb begin
    raw1 = use_rs1 && (rs1 != '0) && (cnt[rs1] != '0);
    raw2 = use_rs2 && (rs2 != '0) && (cnt[rs2] != '0);
    sat  = regwrite && (rd != '0) && is_full(cnt[rd]);
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`ifdef SB_FORWARD_EN
    // The last outstanding write is landing now: take the operand from wd3.
    fwd1 = raw1 && wb_valid && (wb_rd == rs1) && (cnt[rs1] == CNT_ONE);
    fwd2 = raw2 && wb_valid && (wb_rd == rs2) && (cnt[rs2] == CNT_ONE);
`endif
    haz1 = raw1 && !fwd1;
    haz2 = raw2 && !fwd2;

    // rst_n gating keeps the handshake quiet while reset is held.
    stall      = rst_n && issue_valid && !flush && (haz1 || haz2 || sat);
    issue_fire = rst_n && issue_valid && !flush && !(haz1 || haz2 || sat);
    fwd_rs1    = rst_n && fwd1;
    fwd_rs2    = rst_n && fwd2;

    // x0 is never tracked, so both strobes ignore address 0.
    inc_any       = issue_fire && regwrite && (rd != '0);
    dec_any       = wb_valid && (wb_rd != '0) && (cnt[wb_rd] != '0);
    underflow_hit = wb_valid && (wb_rd != '0) && (cnt[wb_rd] == '0);
  end

  // Next counter values: simultaneous inc and dec on a register cancel.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_next[r] = cnt[r];
      if (inc_any && (rd == AW'(r)) && !(dec_any && (wb_rd == AW'(r))))
        cnt_next[r] = cnt[r] + CNT_ONE;
      else if (dec_any && (wb_rd == AW'(r)) && !(inc_any && (rd == AW'(r))))
        cnt_next[r] = cnt[r] - CNT_ONE;
    end
  end

  // Register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      outstanding   <= '0;
      stall_cycles  <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_next[r];
      case ({inc_any, dec_any})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      if (stall) stall_cycles <= sat_inc(stall_cycles);
      if (underflow_hit) err_underflow <= 1'b1;
    end
  end

  assign busy = (outstanding != '0);

endmodule

`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
// Directed testbench for decode_scoreboard (AW=5, CNT_W=2, PERF_W=32).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 unit later and registered outputs 1 unit after the next edge.
`timescale 1ns/1ps

module tb_decode_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        use_rs1, use_rs2, regwrite, flush, wb_valid;
  logic        stall, issue_fire, busy, err_underflow, fwd_rs1, fwd_rs2;
  logic [6:0]  outstanding;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stalls = 0;

  always #5 clk = ~clk;

  decode_scoreboard #(.AW(5), .CNT_W(2), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rd(rd), .regwrite(regwrite),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .issue_fire(issue_fire), .busy(busy),
    .outstanding(outstanding), .stall_cycles(stall_cycles),
    .err_underflow(err_underflow), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; use_rs1 = 0; use_rs2 = 0; regwrite = 0; flush = 0;
    wb_valid = 0; rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] r);
    idle(); issue_valid = 1; regwrite = 1; rd = r;
  endtask

  task automatic wb(input logic [4:0] r);
    idle(); wb_valid = 1; wb_rd = r;
  endtask

  initial begin
    // Reset with a would-be issue present
    rst_n = 0;
    issue_wr(5);
    #3;
    check("rst_issue_fire", issue_fire, 0);
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_err", err_underflow, 0);
    check("rst_fwd", {fwd_rs1, fwd_rs2}, 0);
    #9 rst_n = 1;  // t=12, between edges
    #1;
    check("add_x5_fire", issue_fire, 1);
    tick();
    check("x5_outstanding", outstanding, 1);
    check("x5_busy", busy, 1);

    // Dependent reader of x5, writes x6
    idle(); issue_valid = 1; use_rs1 = 1; rs1 = 5; regwrite = 1; rd = 6;
    #1;
    check("raw_stall", stall, 1);
    check("raw_no_fire", issue_fire, 0);
    tick(); exp_stalls++;
    check("stall_cnt_1", stall_cycles, exp_stalls);

    wb_valid = 1; wb_rd = 5;
    #1;
`ifdef SB_FORWARD_EN
    check("fwd_stall", stall, 0);
    check("fwd_rs1", fwd_rs1, 1);
    check("fwd_fire", issue_fire, 1);
    tick();
    idle();
`else
    check("wb_cycle_stall", stall, 1);
    check("no_fwd", fwd_rs1, 0);
    tick(); exp_stalls++;
    check("after_wb_outstanding", outstanding, 0);
    wb_valid = 0; wb_rd = 0;
    #1;
    check("release_stall", stall, 0);
    check("release_fire", issue_fire, 1);
    tick();
    idle();
`endif
    check("x6_outstanding", outstanding, 1);
    check("stall_cnt_2", stall_cycles, exp_stalls);
    wb(6); tick(); idle();
    check("clear_x6", outstanding, 0);
    check("clear_x6_busy", busy, 0);

    // Saturation on x7
    for (int i = 0; i < 3; i++) begin
      issue_wr(7);
      #1;
      check("sat_fill_fire", issue_fire, 1);
      tick();
    end
    check("sat_outstanding3", outstanding, 3);
    issue_wr(7);
    #1;
    check("sat_stall", stall, 1);
    tick(); exp_stalls++;
    wb_valid = 1; wb_rd = 7;
    #1;
    check("sat_stall_during_wb", stall, 1);
    tick(); exp_stalls++;
    wb_valid = 0; wb_rd = 0;
    #1;
    check("sat_outstanding2", outstanding, 2);
    check("sat_release_fire", issue_fire, 1);
    tick();
    check("sat_outstanding3b", outstanding, 3);
    check("sat_stall_cnt", stall_cycles, exp_stalls);
    for (int i = 0; i < 3; i++) begin wb(7); tick(); end
    idle();
    check("sat_drained", outstanding, 0);

    // Same-cycle issue and writeback on x3
    issue_wr(3); tick();
    issue_wr(3); wb_valid = 1; wb_rd = 3;
    #1;
    check("same_cycle_fire", issue_fire, 1);
    tick(); idle();
    check("same_cycle_outstanding", outstanding, 1);
    wb(3); tick(); idle();
    check("x3_drained", outstanding, 0);
    check("x3_no_underflow", err_underflow, 0);

    // x0 is never tracked
    issue_wr(0); use_rs1 = 1; rs1 = 0; wb_valid = 1; wb_rd = 0;
    #1;
    check("x0_stall", stall, 0);
    check("x0_fire", issue_fire, 1);
    tick(); idle();
    check("x0_outstanding", outstanding, 0);
    check("x0_err", err_underflow, 0);

    // Underflow on x9
    wb(9); tick(); idle();
    check("underflow_set", err_underflow, 1);
    check("underflow_outstanding", outstanding, 0);
    tick();
    check("underflow_sticky", err_underflow, 1);

    // Flush of a hazarding instruction
    issue_wr(10); tick();
    idle(); issue_valid = 1; use_rs1 = 1; rs1 = 10; regwrite = 1; rd = 11; flush = 1;
    #1;
    check("flush_stall", stall, 0);
    check("flush_fire", issue_fire, 0);
    tick(); idle();
    check("flush_outstanding", outstanding, 1);
    check("flush_stall_cnt", stall_cycles, exp_stalls);

    // Reset with four writes pending
    issue_wr(12); tick();
    issue_wr(13); tick();
    issue_wr(14); tick();
    idle();
    check("pending4", outstanding, 4);
    check("pending4_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_outstanding", outstanding, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_err", err_underflow, 0);
    check("async_rst_stall_cnt", stall_cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
- Register-hazard scheduler for the decode stage of the pipelined RISC-V core.
- Tracks outstanding register writes issued from decode and not yet written back.
- Stalls decode on RAW/WAW hazards against the register file, and releases the stall when writeback occurs.
- Sits between the decode stage (rs1/rs2/rd fields, regwrite) and the writeback port (rf we3/ad3).

Parameters:
AW, 5, register address width; NREG = 2**AW registers tracked.
CNT_W, 2, width of per-register outstanding-write counter (max 2**CNT_W-1 in flight per register).
PERF_W, 32, width of stall-cycle performance counter.

Ports:
clk  input  1  core clock, all state updated on rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  decode holds a valid instruction this cycle
rs1  input  AW  source register 1 address (instr[19:15])
rs2  input  AW  source register 2 address (instr[24:20])
use_rs1  input  1  instruction reads rs1
use_rs2  input  1  instruction reads rs2
rd  input  AW  destination address (instr[11:7])
regwrite  input  1  instruction writes rd
flush  input  1  kill instruction in decode (branch/jump redirect)
wb_valid  input  1  writeback this cycle (rf we3)
wb_rd  input  AW  writeback address (rf ad3)
stall  output  1  hold fetch/decode this cycle
issue_fire  output  1  instruction leaves decode this cycle
busy  output  1  at least one write outstanding
outstanding  output  AW+CNT_W  total outstanding writes
stall_cycles  output  PERF_W  saturating count of stalled cycles
err_underflow  output  1  sticky: writeback to a register with zero outstanding
fwd_rs1, fwd_rs2  output  1  bypass select (only with SB_FORWARD_EN; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): all counters cnt[r]=0, outstanding=0, stall_cycles=0, err_underflow=0. stall, issue_fire, busy, fwd_* are 0 while in reset. Reset mid-operation discards all pending state immediately.
- Register x0 is never tracked. Issue or writeback with address 0 leaves the state unchanged and does not trigger an underflow.
- Hazard conditions (combinational, same cycle):
  - raw1 = use_rs1 & rs1!=0 & cnt[rs1]!=0
  - raw2 = use_rs2 & rs2!=0 & cnt[rs2]!=0
  - sat = regwrite & rd!=0 & cnt[rd]==max
- stall = issue_valid & !flush & (raw1 | raw2 | sat).
- issue_fire = issue_valid & !flush & !stall.
- Flushed instruction: never issues, never modifies state, never counts as a stall.
- Counter update per register r on the next edge: cnt[r] + inc - dec.
  - inc = issue_fire & regwrite & rd==r.
  - dec = wb_valid & wb_rd==r & cnt[r]!=0.
  - Simultaneous inc and dec on the same r leaves cnt unchanged.
- Underflow: wb_valid with wb_rd!=0 and cnt[wb_rd]==0 sets err_underflow (sticky until reset). The counter stays at 0.
- The writeback decrement is visible one cycle later. Without forwarding, an instruction stalled on rX issues in the cycle after the edge where cnt[rX] reaches 0, giving a minimum one-cycle stall bubble.
- outstanding = sum of all cnt, kept as a registered running total (+inc, -dec). busy = outstanding!=0.
- stall_cycles increments on every cycle where stall=1 and saturates at all-ones.
- State machine per register: IDLE (cnt=0) -> PENDING (cnt 1..max-1) -> FULL (cnt=max).
  - Issue moves the register up one state; writeback moves it down one.
  - FULL blocks any further issue targeting that rd.

Optional Feature:
- Macro: SB_FORWARD_EN.
- Defined:
  - If wb_valid & wb_rd==rs1 & cnt[rs1]==1, raw1 is suppressed and fwd_rs1=1 (same rule for rs2/fwd_rs2). Decode selects wd3 as the operand, giving a zero-bubble issue in the writeback cycle.
  - sat is unaffected by forwarding.
- Undefined: fwd_rs1=fwd_rs2=0 and the hazard terms are exactly as above.

Test Plan:
- Reset then issue `add x5` (rd=5, regwrite) -> issue_fire=1, next cycle cnt[5]=1, busy=1, outstanding=1; a following `use_rs1 rs1=5` holds stall=1.
- Pending x5, wb_valid wb_rd=5 -> next cycle stall=0 and the dependent instruction fires. With SB_FORWARD_EN: stall=0 in the wb cycle itself, fwd_rs1=1.
- Issue rd=7 three times with CNT_W=2 and no wb -> 4th issue to rd=7 has stall=1 (sat). One wb to 7 -> 4th issues next cycle.
- Same-cycle issue rd=3 and wb_rd=3 with cnt[3]=1 -> cnt[3] stays 1, outstanding unchanged.
- rd=0 issue, wb_rd=0, use_rs1 rs1=0 -> no stall, outstanding=0, err_underflow=0. wb_rd=9 with cnt[9]=0 -> err_underflow=1, sticky.
- Hazard present with flush=1 -> stall=0, issue_fire=0, no state change, stall_cycles unchanged. Assert rst_n=0 with 4 writes pending -> outstanding=0 and busy=0 immediately.
